// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared operation codes, FSM state encoding and small
// decode helpers for the iterative RV32M divider.
package div_unit_pkg;

    // Operation encodings as issued by the decoder
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Divider sequencing states
    typedef enum logic [1:0] {
        DIV_S_IDLE  = 2'b00,
        DIV_S_CALC  = 2'b01,
        DIV_S_FIXUP = 2'b10
    } div_state_e;

    // DIV and REM treat their operands as two's complement
    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    // REM and REMU return the remainder, the others the quotient
    function automatic logic is_rem_op(input logic [1:0] op);
        return !((op == DIV_OP_DIV) || (op == DIV_OP_DIVU));
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes.
// Shifts the next dividend bit into the partial remainder, subtracts the
// divisor when it fits and shifts the resulting quotient bit in.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff_low;
    logic             fits;

    // Partial remainder is one bit wider than the operands so the compare
    // against a full-width divisor magnitude never overflows. When the
    // divisor fits, the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    always_comb begin
        partial  = {rem_i, quo_i[WIDTH-1]};
        fits     = (partial >= {1'b0, dvs_i});
        diff_low = partial[WIDTH-1:0] - dvs_i;
        rem_o    = fits ? diff_low : partial[WIDTH-1:0];
        quo_o    = {quo_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on operand magnitudes, sign fix-up applied to
// the final iteration, result and done registered.
// Optional feature macro: DIV_FAST_SPECIAL_EN - divide-by-zero and signed
// overflow are answered directly from IDLE with done one cycle after accept.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    logic [1:0]       op_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic             ovf_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             ready_q;

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] final_d;
    logic [WIDTH-1:0] fast_result_d;
    logic             start_signed;
    logic             start_div0;
    logic             start_ovf;
    logic             fast_hit;

    // Two's complement magnitude for signed ops; unsigned ops pass through
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic            sgn);
        return (sgn && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    // Classify the incoming request and precompute the special-case answer
    always_comb begin
        start_signed  = is_signed_op(op);
        start_div0    = (divisor == '0);
        start_ovf     = start_signed && (dividend == MIN_NEG) && (divisor == '1);
        fast_result_d = is_rem_op(op) ? (start_div0 ? dividend : '0)
                                      : (start_div0 ? '1 : MIN_NEG);
    end

`ifdef DIV_FAST_SPECIAL_EN
    assign fast_hit = start_div0 || start_ovf;
`else
    assign fast_hit = 1'b0;
`endif

    // Sign fix-up of the last iteration, with the RISC-V special values
    // forced over whatever the magnitude datapath produced
    always_comb begin
        logic [WIDTH-1:0] q_fix;
        logic [WIDTH-1:0] r_fix;
        q_fix = neg_quo_q ? (~quo_d + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_d;
        r_fix = neg_rem_q ? (~rem_d + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_d;
        if (div_zero_q) begin
            q_fix = '1;
            r_fix = dividend_q;
        end
        if (ovf_q) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end
        final_d = is_rem_op(op_q) ? r_fix : q_fix;
    end

    // Sequencer: accept in IDLE or in the done (FIXUP) cycle, iterate in
    // CALC, register the fixed-up result on the final iteration so done and
    // ready rise together in FIXUP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= DIV_S_IDLE;
            op_q       <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            dividend_q <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            count_q    <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DIV_S_IDLE, DIV_S_FIXUP: begin
                    state_q <= DIV_S_IDLE;
                    ready_q <= 1'b1;
                    if (start) begin
                        op_q       <= op;
                        neg_quo_q  <= start_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_q  <= start_signed && dividend[WIDTH-1];
                        div_zero_q <= start_div0;
                        ovf_q      <= start_ovf;
                        dividend_q <= dividend;
                        if (fast_hit) begin
                            result_q <= fast_result_d;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= DIV_S_CALC;
                            ready_q <= 1'b0;
                            rem_q   <= '0;
                            quo_q   <= magnitude(dividend, start_signed);
                            dvs_q   <= magnitude(divisor, start_signed);
                            count_q <= CW'(WIDTH - 1);
                        end
                    end
                end
                DIV_S_CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q - 1'b1;
                    if (count_q == '0) begin
                        state_q  <= DIV_S_FIXUP;
                        ready_q  <= 1'b1;
                        done_q   <= 1'b1;
                        result_q <= final_d;
                    end
                end
                default: begin
                    state_q <= DIV_S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign busy   = ~ready_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector self-checking bench for div_unit.
// Latency expectations for special cases follow DIV_FAST_SPECIAL_EN.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int NORMAL_CYCLE = 33;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPECIAL_CYCLE = 1;
`else
    localparam int SPECIAL_CYCLE = 33;
`endif
    localparam int MAX_WAIT = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checkCount = 0;
    int failCount = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one operation, scramble the inputs after accept, then check the
    // done cycle, the result, ready in the done cycle and the single pulse
    task automatic applyStimulus(input logic [1:0] opSel, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expResult,
                                 input int expCycle, input string tag);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        op = opSel;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom_range(3, 0));
        dividend = $urandom;
        divisor = $urandom;
        cyc = 1;
        while (done !== 1'b1 && cyc < MAX_WAIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, " latency"}, 32'(cyc), 32'(expCycle));
        checkOutput({tag, " result"}, result, expResult);
        checkOutput({tag, " ready"}, {31'b0, ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, " done pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int doneSeen;

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", {31'b0, ready}, 32'd1);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        applyStimulus(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_CYCLE, "divu 100/7");
        applyStimulus(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, NORMAL_CYCLE, "remu 100/7");
        applyStimulus(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_CYCLE, "div -7/2");
        applyStimulus(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_CYCLE, "rem -7/2");
        applyStimulus(DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORMAL_CYCLE, "div 7/-2");
        applyStimulus(DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, NORMAL_CYCLE, "rem 7/-2");
        applyStimulus(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORMAL_CYCLE, "divu max/1");
        applyStimulus(DIV_OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, NORMAL_CYCLE, "remu max/16");
        applyStimulus(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NORMAL_CYCLE, "divu min/max");
        applyStimulus(DIV_OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORMAL_CYCLE, "remu min/max");

        $display("[TB] special cases");
        applyStimulus(DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_CYCLE, "div 5/0");
        applyStimulus(DIV_OP_REMU, 32'd5, 32'd0, 32'd5, SPECIAL_CYCLE, "remu 5/0");
        applyStimulus(DIV_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_CYCLE, "div -5/0");
        applyStimulus(DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_CYCLE, "rem -5/0");
        applyStimulus(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_CYCLE, "div ovf");
        applyStimulus(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_CYCLE, "rem ovf");

        $display("[TB] start while busy");
        @(negedge clk);
        start = 1'b1;
        op = DIV_OP_DIVU;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < MAX_WAIT) begin
            if (cyc == 10) begin
                checkOutput("busy mid-run", {31'b0, busy}, 32'd1);
                start = 1'b1;
                op = DIV_OP_DIVU;
                dividend = 32'd1000;
                divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        checkOutput("ignored start latency", 32'(cyc), 32'(NORMAL_CYCLE));
        checkOutput("ignored start result", result, 32'd14);
        @(posedge clk);
        #1;
        checkOutput("ignored start no requeue", {31'b0, done}, 32'd0);

        $display("[TB] reset mid-run");
        @(negedge clk);
        start = 1'b1;
        op = DIV_OP_DIVU;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 15) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort ready", {31'b0, ready}, 32'd1);
        checkOutput("abort done", {31'b0, done}, 32'd0);
        checkOutput("abort result", result, 32'd0);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("abort no done", 32'(doneSeen), 32'd0);

        $display("[TB] back-to-back");
        @(negedge clk);
        start = 1'b1;
        op = DIV_OP_DIVU;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < MAX_WAIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("b2b first latency", 32'(cyc), 32'(NORMAL_CYCLE));
        checkOutput("b2b first result", result, 32'd14);
        start = 1'b1;
        op = DIV_OP_DIV;
        dividend = 32'hFFFF_FFF9;
        divisor = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b accepted busy", {31'b0, busy}, 32'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < MAX_WAIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("b2b second latency", 32'(cyc), 32'(NORMAL_CYCLE));
        checkOutput("b2b second result", result, 32'hFFFF_FFFD);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
